// File: rtl/kb_event_queue_if.sv
// kb_event_queue_if: PS/2 keeper inputs plus CPU register bus (master drives strobes, slave returns rdata/irq)
`ifndef KB_ADDR_WIDTH
`define KB_ADDR_WIDTH 8
`endif
interface kb_event_queue_if;
  logic                      ps2_ready;
  logic [7:0]                ps2_byte;
  logic                      mem_read;
  logic                      mem_write;
  logic [`KB_ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]               mem_wdata;
  logic [31:0]               mem_rdata;
  logic                      kb_irq;
  modport master (
    output ps2_ready, ps2_byte, mem_read, mem_write, mem_addr, mem_wdata,
    input  mem_rdata, kb_irq
  );
  modport slave (
    input  ps2_ready, ps2_byte, mem_read, mem_write, mem_addr, mem_wdata,
    output mem_rdata, kb_irq
  );
endinterface

// File: rtl/kb_event_queue.sv
// kb_event_queue: folds E0/F0 prefixes into events, queues them for CPU pops via DATA/STATUS/CTRL; ports clk, reset_n, bus (ps2_ready/ps2_byte in, mem_* register bus, kb_irq out)
`ifndef KB_ADDR_WIDTH
`define KB_ADDR_WIDTH 8
`endif
module kb_event_queue #(
  parameter int DEPTH = 16,
  parameter int PTR_W = 4
) (
  input logic              clk,
  input logic              reset_n,
  kb_event_queue_if.slave  bus
);
  localparam int AW = `KB_ADDR_WIDTH;
  localparam logic [AW-1:0] A_DATA = AW'(0);
  localparam logic [AW-1:0] A_STAT = AW'(1);
  localparam logic [AW-1:0] A_CTRL = AW'(2);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, S_E0, S_F0, S_E0F0} state_t;
  state_t state_q, state_d;
  logic ready_q;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0] count_q, count_d;
  logic ovf_q, ovf_d, en_q, en_d, irq_en_q, irq_en_d, irq_q, irq_d;
  logic [31:0] rdata_q, rdata_d, status;
  logic [9:0] mem_q [DEPTH];
  logic [9:0] ev;
  logic byte_ok, push, pop, do_push, do_pop, empty, full, wr_ctrl, flush, clr_ovf;
  always_comb begin
    byte_ok = bus.ps2_ready & ~ready_q & en_q;
    empty = count_q == '0;
    full = count_q == FULL_CNT;
    wr_ctrl = bus.mem_write & (bus.mem_addr == A_CTRL);
    flush = wr_ctrl & bus.mem_wdata[2];
    clr_ovf = wr_ctrl & bus.mem_wdata[3];
    pop = bus.mem_read & (bus.mem_addr == A_DATA) & ~empty;
    state_d = state_q;
    push = 1'b0;
    ev = {2'b00, bus.ps2_byte};
    if (byte_ok)
      case (state_q)
        IDLE: begin
          if (bus.ps2_byte == 8'hE0) state_d = S_E0;
          else if (bus.ps2_byte == 8'hF0) state_d = S_F0;
          else push = 1'b1;
        end
        S_E0: begin
          if (bus.ps2_byte == 8'hF0) state_d = S_E0F0;
          else if (bus.ps2_byte != 8'hE0) begin
            push = 1'b1;
            ev[9] = 1'b1;
            state_d = IDLE;
          end
        end
        S_F0: begin
          push = 1'b1;
          ev[8] = 1'b1;
          state_d = IDLE;
        end
        default: begin
          push = 1'b1;
          ev[9:8] = 2'b11;
          state_d = IDLE;
        end
      endcase
    if (flush | ~en_q) state_d = IDLE;
    do_pop = pop & ~flush;
    // a full FIFO still accepts a push when the same cycle frees the head slot
    do_push = push & ~flush & (~full | do_pop);
    count_d = flush ? '0 : count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
    wr_ptr_d = flush ? '0 : wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = flush ? '0 : rd_ptr_q + PTR_W'(do_pop);
    ovf_d = ~clr_ovf & (ovf_q | (push & ~flush & full & ~do_pop));
    en_d = wr_ctrl ? bus.mem_wdata[0] : en_q;
    irq_en_d = wr_ctrl ? bus.mem_wdata[1] : irq_en_q;
    irq_d = irq_en_d & (count_d != '0);
    status = '0;
    status[PTR_W:0] = count_q;
    status[16] = empty;
    status[17] = full;
    status[18] = ovf_q;
    status[24] = state_q != IDLE;
    rdata_d = rdata_q;
    if (bus.mem_read)
      rdata_d = bus.mem_addr == A_DATA ? (empty ? '0 : {1'b1, 21'b0, mem_q[rd_ptr_q]}) :
                bus.mem_addr == A_STAT ? status :
                bus.mem_addr == A_CTRL ? {30'b0, irq_en_q, en_q} : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      ready_q <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
      en_q <= 1'b1;
      irq_en_q <= 1'b0;
      irq_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      ready_q <= bus.ps2_ready;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
      en_q <= en_d;
      irq_en_q <= irq_en_d;
      irq_q <= irq_d;
      rdata_q <= rdata_d;
    end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_ptr_q] <= ev;
  assign bus.mem_rdata = rdata_q;
  assign bus.kb_irq = irq_q;
endmodule
